coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Snoopy MESI coherence controller for `CPUS` private L1 data caches sharing one memory port. It arbitrates miss requests round-robin and broadcasts a snoop to every other cache. It collects hit and dirty responses, then supplies the block, either cache-to-cache or from memory, writing back dirty data on read-sharing. It returns the MESI end state to the requester and keeps per-transition statistics. It sits between the per-core cache coherence ports and the shared memory bus.

## Interface
Parameters:
- `CPUS`, 2: number of caches (2–8).
- `BLOCK_SIZE`, 2: words per block; block width `BW = 32*BLOCK_SIZE`.

Ports (index `i` means one bit or slice per cache):
- `CLK` in 1: sole clock.
- `RST` in 1: synchronous, active-high reset.
- `req` in CPUS: miss request, held until `resp_valid[i]`.
- `req_write` in CPUS: 1 = write miss (BusRdX), 0 = read miss (BusRd).
- `req_addr` in CPUS*32: block address per cache.
- `resp_valid` out CPUS: one-cycle completion pulse.
- `resp_state` out 2: `cc_end_state` granted to the requester.
- `resp_data` out BW: block for the requester.
- `snoop_req` out CPUS: snoop request per target.
- `snoop_addr` out 32: snooped address.
- `snoop_inv` out 1: targets must invalidate on hit.
- `snoop_busy` in CPUS: target cannot perform a tag lookup this cycle.
- `snoop_hit` in CPUS: valid in a cycle with `snoop_req[i] && !snoop_busy[i]`.
- `snoop_dirty` in CPUS: valid in the same cycle as `snoop_hit`.
- `snoop_data` in CPUS*BW: valid in the same cycle as `snoop_hit`.
- `snoop_complete` out CPUS: one-cycle pulse ending the snoop.
- `mem_ren` out 1: memory read strobe.
- `mem_wen` out 1: memory write strobe.
- `mem_addr` out 32: memory address.
- `mem_wdata` out BW: memory write data.
- `mem_rdata` in BW: memory read data.
- `mem_ready` in 1: memory access complete.
- `stat_to_i` out 32: invalidating-hit counter.
- `stat_to_s` out 32: read-share counter.
- `stat_to_e` out 32: exclusive/modified grant counter.

## Operation
- FSM states: IDLE, GRANT, SNOOP, DECIDE, WB, MEMRD, RESP.
- IDLE: if any `req` is set, the arbiter picks the winner `g` and the FSM goes to GRANT.
- Arbiter policy: round-robin, starting from the index after the last grant. The pointer is 0 after reset.
- GRANT: latch `g`, `req_addr[g]` and `req_write[g]`, then go to SNOOP.
- SNOOP:
  - Drive `snoop_req[j]` for every `j != g`; drive `snoop_addr` and `snoop_inv = req_write`.
  - For each target, capture hit, dirty and data on the first cycle it is not busy, set its done bit and drop its `snoop_req` the next cycle.
  - When all done bits are set, go to DECIDE.
  - With `CPUS` = 1 there are no targets; go straight to DECIDE.
- DECIDE, with `H` = any hit and `D` = lowest-index dirty hit:
  - Read, `H` and `D`: forward `D`'s data, write it back, go to WB. End state SHARED.
  - Read, `H`, no dirty hit: go to MEMRD. End state SHARED.
  - Read, no hit: go to MEMRD. End state EXCLUSIVE.
  - Write, `D` exists: forward `D`'s data, go to RESP. No writeback. End state MODIFIED.
  - Write, otherwise: go to MEMRD. End state MODIFIED.
- More than one dirty hit is illegal; flag it with an assertion.
- WB: hold `mem_wen`, `mem_addr` and `mem_wdata` until `mem_ready`, then go to RESP.
- MEMRD: hold `mem_ren` until `mem_ready`; latch `mem_rdata` into `resp_data`; go to RESP.
- RESP:
  - Pulse `resp_valid[g]` and drive `resp_state`.
  - Pulse `snoop_complete[j]` for every `j != g` in the same cycle.
  - Advance the arbiter pointer; return to IDLE.
- Counters, updated in RESP, saturating at all-ones:
  - `stat_to_i` += number of hits when `snoop_inv` is set.
  - `stat_to_s` += 1 on a SHARED grant.
  - `stat_to_e` += 1 on an EXCLUSIVE or MODIFIED grant.

## Timing
- Reset values: all outputs 0. `resp_data`, `mem_wdata` and `mem_addr` are 0; `resp_state` is INVALID. FSM to IDLE, pointer 0, counters 0.
- Reset mid-transaction aborts on the next edge. No `resp_valid` or `snoop_complete` is issued; caches treat reset as global.
- Dirty forward on a write with no busy targets: `req` rises at cycle 0, GRANT 1, SNOOP 2, DECIDE 3, RESP 4.
- Memory paths add one cycle per memory wait state. `mem_ready` in the first WB/MEMRD cycle gives RESP at cycle 5.
- A `snoop_busy` target extends SNOOP by one cycle per busy cycle; there is no timeout.
- `req` changes while not granted are ignored until IDLE. Requests arriving during a transaction wait.
- One transaction is outstanding at a time. `resp_valid` is never asserted for two caches at once.

## Structure
- `coherence_pkg`:
  - `cc_end_state`, `word_t`.
  - FSM enum.
  - `cache_coherence_statistics_t`.
  - Helper to compute `BW` from `BLOCK_SIZE`.
- Sub-module `coherence_rr_arbiter #(N)`: inputs `req`, `advance`; output one-hot `grant` plus index.

## Test plan
- Cache 0 read miss, no hits; memory returns `0xAAAA_BBBB_CCCC_DDDD` after 2 waits → `resp_state` EXCLUSIVE, data matches, `resp_valid[0]` at cycle 7, `stat_to_e` = 1.
- Cache 1 read, cache 0 dirty hit with `0x1234_5678_9ABC_DEF0` → `mem_wen` with that data, response SHARED with the same data, `stat_to_s` = 1.
- Cache 0 write, caches 1–3 clean hits (`CPUS` = 4) → `snoop_inv` = 1, MEMRD, MODIFIED, `stat_to_i` = 3.
- Caches 0 and 1 request in the same cycle, twice each → grant order 0, 1, 0, 1.
- Target busy for 5 cycles → `snoop_req` held, RESP delayed by exactly 5 cycles. `RST` asserted in WB → all outputs 0 on the next edge, no `resp_valid`.

Source files
------------

// File: rtl/coherence_pkg.sv
// coherence_pkg
// Shared types and helpers for the snoopy MESI bus controller:
//   cc_end_state                  - MESI state granted to a requester
//   word_t                        - 32-bit bus word / address
//   fsm_state_t                   - controller FSM states
//   cache_coherence_statistics_t  - transition counters
//   block_width / idx_width       - derived widths
//   sat_add                       - saturating 32-bit add for the counters
package coherence_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        CC_INVALID   = 2'd0,
        CC_SHARED    = 2'd1,
        CC_EXCLUSIVE = 2'd2,
        CC_MODIFIED  = 2'd3
    } cc_end_state;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SNOOP,
        ST_DECIDE,
        ST_WB,
        ST_MEMRD,
        ST_RESP
    } fsm_state_t;

    typedef struct packed {
        word_t to_i;
        word_t to_s;
        word_t to_e;
    } cache_coherence_statistics_t;

    function automatic int block_width(input int block_size);
        return 32 * block_size;
    endfunction

    // Index width that stays at least one bit wide for a single cache.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/coherence_rr_arbiter.sv
// coherence_rr_arbiter
// Round-robin arbiter. Search starts at the pointer, which moves to the
// entry after the served index when advance is pulsed.
// Ports:
//   clk, srst    - clock, synchronous active-high reset (pointer -> 0)
//   req          - request vector
//   advance      - pulse when the served transaction completes
//   served_idx   - index of the transaction that completed
//   grant        - one-hot winner (combinational)
//   grant_idx    - binary index of the winner
module coherence_rr_arbiter
    import coherence_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] served_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (int'(served_idx) == N - 1) ? '0 : served_idx + 1'b1;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
// Snoopy MESI controller: arbitrates cache misses, snoops every other cache,
// supplies the block cache-to-cache or from memory (writing back dirty data
// on read sharing), returns the MESI end state and counts transitions.
// Ports:
//   CLK, RST                      - clock, synchronous active-high reset
//   req/req_write/req_addr        - per-cache miss requests
//   resp_valid/resp_state/resp_data - completion to the requester
//   snoop_*                       - snoop broadcast and target responses
//   mem_*                         - shared memory port
//   stat_to_i/s/e                 - saturating transition counters
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter int CPUS       = 2,
    parameter int BLOCK_SIZE = 2,
    localparam int BW = block_width(BLOCK_SIZE),
    localparam int IW = idx_width(CPUS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [CPUS-1:0]    req,
    input  logic [CPUS-1:0]    req_write,
    input  logic [CPUS*32-1:0] req_addr,
    output logic [CPUS-1:0]    resp_valid,
    output logic [1:0]         resp_state,
    output logic [BW-1:0]      resp_data,
    output logic [CPUS-1:0]    snoop_req,
    output logic [31:0]        snoop_addr,
    output logic               snoop_inv,
    input  logic [CPUS-1:0]    snoop_busy,
    input  logic [CPUS-1:0]    snoop_hit,
    input  logic [CPUS-1:0]    snoop_dirty,
    input  logic [CPUS*BW-1:0] snoop_data,
    output logic [CPUS-1:0]    snoop_complete,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [31:0]        mem_addr,
    output logic [BW-1:0]      mem_wdata,
    input  logic [BW-1:0]      mem_rdata,
    input  logic               mem_ready,
    output logic [31:0]        stat_to_i,
    output logic [31:0]        stat_to_s,
    output logic [31:0]        stat_to_e
);

    fsm_state_t                  state_q;
    logic [IW-1:0]               g_q;
    logic [CPUS-1:0]             gnt_oh_q;
    logic [CPUS-1:0]             tgt_q;
    logic                        write_q;
    logic [CPUS-1:0]             snoop_req_q, done_q, hit_q, dirty_q;
    logic [BW-1:0]               sdata_q [CPUS];
    logic [CPUS-1:0]             resp_valid_q, snoop_complete_q;
    cc_end_state                 resp_state_q;
    logic [BW-1:0]               resp_data_q, mem_wdata_q;
    logic [31:0]                 snoop_addr_q, mem_addr_q;
    logic                        snoop_inv_q, mem_ren_q, mem_wen_q;
    cache_coherence_statistics_t stats_q;

    logic [CPUS-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;

    coherence_rr_arbiter #(.N(CPUS)) u_arb (
        .clk        (CLK),
        .srst       (RST),
        .req        (req),
        .advance    (state_q == ST_RESP),
        .served_idx (g_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // A target answers in the first cycle its snoop is up and it is not busy.
    logic [CPUS-1:0] cap, done_next;
    assign cap       = snoop_req_q & ~snoop_busy;
    assign done_next = done_q | cap;

    // Lowest-index dirty hit supplies the block.
    logic [CPUS-1:0] dmask;
    logic            d_found;
    logic [IW-1:0]   d_idx;
    logic [31:0]     hit_cnt;
    assign dmask   = hit_q & dirty_q;
    assign d_found = |dmask;

    always_comb begin
        d_idx   = '0;
        hit_cnt = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (dmask[j]) d_idx = IW'(j);
        end
        for (int j = 0; j < CPUS; j++) begin
            hit_cnt = hit_cnt + 32'(hit_q[j]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= ST_IDLE;
            g_q              <= '0;
            gnt_oh_q         <= '0;
            tgt_q            <= '0;
            write_q          <= 1'b0;
            snoop_req_q      <= '0;
            done_q           <= '0;
            hit_q            <= '0;
            dirty_q          <= '0;
            for (int j = 0; j < CPUS; j++) sdata_q[j] <= '0;
            resp_valid_q     <= '0;
            snoop_complete_q <= '0;
            resp_state_q     <= CC_INVALID;
            resp_data_q      <= '0;
            mem_wdata_q      <= '0;
            snoop_addr_q     <= '0;
            mem_addr_q       <= '0;
            snoop_inv_q      <= 1'b0;
            mem_ren_q        <= 1'b0;
            mem_wen_q        <= 1'b0;
            stats_q          <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        g_q      <= arb_idx;
                        gnt_oh_q <= arb_grant;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    snoop_addr_q <= req_addr[int'(g_q)*32 +: 32];
                    write_q      <= req_write[g_q];
                    snoop_inv_q  <= req_write[g_q];
                    tgt_q        <= ~gnt_oh_q;
                    snoop_req_q  <= ~gnt_oh_q;
                    done_q       <= '0;
                    hit_q        <= '0;
                    dirty_q      <= '0;
                    state_q      <= ST_SNOOP;
                end
                ST_SNOOP: begin
                    for (int j = 0; j < CPUS; j++) begin
                        if (cap[j]) begin
                            hit_q[j]   <= snoop_hit[j];
                            dirty_q[j] <= snoop_dirty[j];
                            sdata_q[j] <= snoop_data[j*BW +: BW];
                        end
                    end
                    snoop_req_q <= snoop_req_q & ~cap;
                    done_q      <= done_next;
                    // With no targets tgt_q is zero, so this falls straight through.
                    if (done_next == tgt_q) state_q <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    mem_addr_q <= snoop_addr_q;
                    if (!write_q) begin
                        if (d_found) begin
                            resp_data_q  <= sdata_q[d_idx];
                            mem_wdata_q  <= sdata_q[d_idx];
                            mem_wen_q    <= 1'b1;
                            resp_state_q <= CC_SHARED;
                            state_q      <= ST_WB;
                        end else begin
                            mem_ren_q    <= 1'b1;
                            resp_state_q <= (|hit_q) ? CC_SHARED : CC_EXCLUSIVE;
                            state_q      <= ST_MEMRD;
                        end
                    end else if (d_found) begin
                        // Owner hands its modified copy over; memory stays stale.
                        resp_data_q      <= sdata_q[d_idx];
                        resp_state_q     <= CC_MODIFIED;
                        resp_valid_q     <= gnt_oh_q;
                        snoop_complete_q <= tgt_q;
                        state_q          <= ST_RESP;
                    end else begin
                        mem_ren_q    <= 1'b1;
                        resp_state_q <= CC_MODIFIED;
                        state_q      <= ST_MEMRD;
                    end
                end
                ST_WB: begin
                    if (mem_ready) begin
                        mem_wen_q        <= 1'b0;
                        resp_valid_q     <= gnt_oh_q;
                        snoop_complete_q <= tgt_q;
                        state_q          <= ST_RESP;
                    end
                end
                ST_MEMRD: begin
                    if (mem_ready) begin
                        mem_ren_q        <= 1'b0;
                        resp_data_q      <= mem_rdata;
                        resp_valid_q     <= gnt_oh_q;
                        snoop_complete_q <= tgt_q;
                        state_q          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid_q     <= '0;
                    snoop_complete_q <= '0;
                    snoop_inv_q      <= 1'b0;
                    if (write_q) stats_q.to_i <= sat_add(stats_q.to_i, hit_cnt);
                    if (resp_state_q == CC_SHARED)
                        stats_q.to_s <= sat_add(stats_q.to_s, 32'd1);
                    else
                        stats_q.to_e <= sat_add(stats_q.to_e, 32'd1);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    a_single_dirty: assert property (@(posedge CLK) disable iff (RST)
        (state_q == ST_DECIDE) |-> $onehot0(hit_q & dirty_q));

    assign resp_valid     = resp_valid_q;
    assign resp_state     = resp_state_q;
    assign resp_data      = resp_data_q;
    assign snoop_req      = snoop_req_q;
    assign snoop_addr     = snoop_addr_q;
    assign snoop_inv      = snoop_inv_q;
    assign snoop_complete = snoop_complete_q;
    assign mem_ren        = mem_ren_q;
    assign mem_wen        = mem_wen_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign stat_to_i      = stats_q.to_i;
    assign stat_to_s      = stats_q.to_s;
    assign stat_to_e      = stats_q.to_e;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl
// Directed and randomized transactions against a transaction-level model of
// the MESI protocol (winner, end state, data source, latency, counters).
module tb_coherence_bus_ctrl;
    import coherence_pkg::*;

    localparam int CPUS = 4;
    localparam int BW   = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [CPUS-1:0]    req, req_write;
    logic [CPUS*32-1:0] req_addr;
    logic [CPUS-1:0]    resp_valid;
    logic [1:0]         resp_state;
    logic [BW-1:0]      resp_data;
    logic [CPUS-1:0]    snoop_req;
    logic [31:0]        snoop_addr;
    logic               snoop_inv;
    logic [CPUS-1:0]    snoop_busy, snoop_hit, snoop_dirty;
    logic [CPUS*BW-1:0] snoop_data;
    logic [CPUS-1:0]    snoop_complete;
    logic               mem_ren, mem_wen;
    logic [31:0]        mem_addr;
    logic [BW-1:0]      mem_wdata, mem_rdata;
    logic               mem_ready;
    logic [31:0]        stat_to_i, stat_to_s, stat_to_e;

    coherence_bus_ctrl #(.CPUS(CPUS), .BLOCK_SIZE(2)) dut (
        .CLK(clk), .RST(rst),
        .req(req), .req_write(req_write), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_state(resp_state), .resp_data(resp_data),
        .snoop_req(snoop_req), .snoop_addr(snoop_addr), .snoop_inv(snoop_inv),
        .snoop_busy(snoop_busy), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
        .snoop_data(snoop_data), .snoop_complete(snoop_complete),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stat_to_i(stat_to_i), .stat_to_s(stat_to_s), .stat_to_e(stat_to_e)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Environment configuration for the current batch.
    bit          cfg_hit[CPUS], cfg_dirty[CPUS];
    logic [63:0] cfg_data[CPUS];
    int          cfg_busy[CPUS];
    int          mem_wait;
    logic [63:0] mem_data;
    logic [31:0] addr[CPUS];

    int busy_left[CPUS];
    int wait_left;
    int cycle;

    // Reference model state.
    int m_ptr, m_to_i, m_to_s, m_to_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_responders();
        for (int j = 0; j < CPUS; j++) begin
            snoop_busy[j] = snoop_req[j] && (busy_left[j] > 0);
            if (snoop_busy[j]) busy_left[j]--;
            snoop_hit[j]   = cfg_hit[j];
            snoop_dirty[j] = cfg_dirty[j];
            snoop_data[j*BW +: BW] = cfg_data[j];
        end
        if ((mem_ren || mem_wen) && wait_left == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem_data;
        end else begin
            if (mem_ren || mem_wen) wait_left--;
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cycle++;
        drive_responders();
    endtask

    task automatic clear_cfg();
        for (int j = 0; j < CPUS; j++) begin
            cfg_hit[j]   = 1'b0;
            cfg_dirty[j] = 1'b0;
            cfg_data[j]  = {$urandom, $urandom};
            cfg_busy[j]  = 0;
            addr[j]      = $urandom;
        end
        mem_wait = 0;
        mem_data = {$urandom, $urandom};
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {resp_valid, snoop_req, snoop_complete, snoop_inv, mem_ren, mem_wen, resp_state}, '0);
        chk({tag, "_rdata"}, resp_data, '0);
        chk({tag, "_addr"}, {snoop_addr, mem_addr}, '0);
        chk({tag, "_wdata"}, mem_wdata, '0);
        chk({tag, "_stats"}, {stat_to_i | stat_to_s | stat_to_e}, '0);
    endtask

    // Serve every requester in rmask; each completion is checked against the model.
    task automatic run_batch(input logic [3:0] rmask, input logic [3:0] wbits);
        logic [3:0]  pending, exp_cmpl;
        int          start, guard, g, d, nh, mb, lat;
        bit          snoop_seen, wb_seen, h, w, use_mem, exp_wb;
        logic        inv_obs;
        logic [31:0] saddr_obs, wb_addr;
        logic [63:0] wb_data, exp_data;
        cc_end_state exp_state;
        pending = rmask;
        req_write = wbits;
        req_addr = {addr[3], addr[2], addr[1], addr[0]};
        req = pending;
        cycle = 0; start = 0; guard = 0;
        snoop_seen = 0; wb_seen = 0; inv_obs = 0; saddr_obs = 0; wb_addr = 0; wb_data = 0;
        for (int j = 0; j < CPUS; j++) busy_left[j] = cfg_busy[j];
        wait_left = mem_wait;
        while (pending != 0 && guard < 300) begin
            tick();
            guard++;
            if (|snoop_req && !snoop_seen) begin
                snoop_seen = 1; inv_obs = snoop_inv; saddr_obs = snoop_addr;
            end
            if (mem_wen && !wb_seen) begin
                wb_seen = 1; wb_data = mem_wdata; wb_addr = mem_addr;
            end
            if (resp_valid != 0) begin
                g = 0;
                for (int k = CPUS - 1; k >= 0; k--)
                    if (pending[(m_ptr + k) % CPUS]) g = (m_ptr + k) % CPUS;
                w = wbits[g];
                h = 0; d = -1; nh = 0; mb = 0;
                for (int j = 0; j < CPUS; j++) begin
                    if (j != g) begin
                        if (cfg_hit[j]) begin
                            h = 1; nh++;
                            if (cfg_dirty[j] && d < 0) d = j;
                        end
                        if (cfg_busy[j] > mb) mb = cfg_busy[j];
                    end
                end
                exp_wb = 0;
                if (d >= 0) begin
                    exp_data = cfg_data[d];
                    use_mem = 0;
                    exp_wb = !w;
                    exp_state = w ? CC_MODIFIED : CC_SHARED;
                end else begin
                    exp_data = mem_data;
                    use_mem = 1;
                    exp_state = w ? CC_MODIFIED : (h ? CC_SHARED : CC_EXCLUSIVE);
                end
                lat = 4 + mb + ((use_mem || exp_wb) ? 1 + mem_wait : 0);
                exp_cmpl = ~(4'b0001 << g);
                $display("txn cache=%0d write=%0b hits=%0d dirty_src=%0d state=%0d data=%h cycle=%0d",
                         g, w, nh, d, resp_state, resp_data, cycle - start);
                chk("resp_who", resp_valid, 4'b0001 << g);
                chk("resp_state", resp_state, exp_state);
                chk("resp_data", resp_data, exp_data);
                chk("resp_cycle", cycle - start, lat);
                chk("snoop_cmpl", snoop_complete, exp_cmpl);
                chk("snoop_seen", snoop_seen, 1);
                chk("snoop_inv", inv_obs, w);
                chk("snoop_addr", saddr_obs, addr[g]);
                chk("wb_strobe", wb_seen, exp_wb);
                if (exp_wb) begin
                    chk("wb_data", wb_data, exp_data);
                    chk("wb_addr", wb_addr, addr[g]);
                end
                if (w) m_to_i += nh;
                if (exp_state == CC_SHARED) m_to_s++; else m_to_e++;
                m_ptr = (g + 1) % CPUS;
                pending = pending & ~resp_valid;
                req = pending;
                start = cycle + 1;
                snoop_seen = 0; wb_seen = 0;
                for (int j = 0; j < CPUS; j++) busy_left[j] = cfg_busy[j];
                wait_left = mem_wait;
            end
        end
        chk("batch_done", pending, 0);
        req = '0;
        tick();
        chk("stat_to_i", stat_to_i, m_to_i);
        chk("stat_to_s", stat_to_s, m_to_s);
        chk("stat_to_e", stat_to_e, m_to_e);
    endtask

    initial begin
        logic [3:0] acc, rm, wb;
        int         guard, dsel;
        rst = 1'b1; req = '0; req_write = '0; req_addr = '0;
        snoop_busy = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        m_ptr = 0; m_to_i = 0; m_to_s = 0; m_to_e = 0;
        clear_cfg();
        wait_left = 0;
        for (int j = 0; j < CPUS; j++) busy_left[j] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Read miss, no sharers, two memory waits.
        clear_cfg();
        mem_wait = 2; mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
        run_batch(4'b0001, 4'b0000);

        // Read miss served by a dirty owner with writeback.
        clear_cfg();
        cfg_hit[0] = 1; cfg_dirty[0] = 1; cfg_data[0] = 64'h1234_5678_9ABC_DEF0;
        run_batch(4'b0010, 4'b0000);

        // Write miss invalidating three clean copies.
        clear_cfg();
        cfg_hit[1] = 1; cfg_hit[2] = 1; cfg_hit[3] = 1;
        run_batch(4'b0001, 4'b0001);

        // Simultaneous requests, twice.
        clear_cfg();
        run_batch(4'b0011, 4'b0000);
        run_batch(4'b0011, 4'b0000);

        // Dirty forward on a write with a target busy for five cycles.
        clear_cfg();
        cfg_hit[3] = 1; cfg_dirty[3] = 1; cfg_busy[3] = 5;
        run_batch(4'b0100, 4'b0100);

        // Reset in the middle of a writeback.
        clear_cfg();
        cfg_hit[0] = 1; cfg_dirty[0] = 1; mem_wait = 20;
        wait_left = 20;
        for (int j = 0; j < CPUS; j++) busy_left[j] = 0;
        req_write = '0; req_addr = {addr[3], addr[2], addr[1], addr[0]}; req = 4'b0010;
        guard = 0;
        while (!mem_wen && guard < 30) begin
            tick();
            guard++;
        end
        chk("wb_reached", mem_wen, 1);
        rst = 1'b1; req = '0;
        tick();
        check_zero("mid_rst");
        rst = 1'b0;
        acc = '0;
        repeat (6) begin
            tick();
            acc = acc | resp_valid;
        end
        chk("no_resp_after_rst", acc, 0);
        m_ptr = 0; m_to_i = 0; m_to_s = 0; m_to_e = 0;

        // Randomized batches.
        for (int t = 0; t < 40; t++) begin
            clear_cfg();
            for (int j = 0; j < CPUS; j++) begin
                cfg_hit[j]  = $urandom_range(0, 1);
                cfg_busy[j] = $urandom_range(0, 3);
            end
            dsel = $urandom_range(0, 5);
            if (dsel < CPUS) begin
                cfg_hit[dsel] = 1; cfg_dirty[dsel] = 1;
            end
            mem_wait = $urandom_range(0, 3);
            rm = 4'($urandom_range(1, 15));
            wb = 4'($urandom_range(0, 15));
            run_batch(rm, wb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
